// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared definitions for the two-VC weighted round-robin arbiter:
// FSM state encoding, credit counter width and grant statistics width.
package vc_wrr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERVE0 = 2'd1,
      ST_SERVE1 = 2'd2
   } arb_state_t;

   localparam int CREDIT_W = 4;
   localparam int STATS_W  = 8;

endpackage

// File: rtl/vc_wrr_arbiter_credit.sv
// Grant-credit down-counter shared by both serve states: load a weight,
// decrement once per pop (stopping at zero), flag zero.
module wrr_credit_counter
   import vc_wrr_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                reset_L,
   input  logic                load,
   input  logic [CREDIT_W-1:0] load_val,
   input  logic                dec,
   output logic [CREDIT_W-1:0] credit,
   output logic                zero
);

   // load wins over dec so a turn handover can reload in the same cycle as the last pop
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         credit <= '0;
      end else if (load) begin
         credit <= load_val;
      end else if (dec && (credit != '0)) begin
         credit <= credit - 1'b1;
      end
   end

   assign zero = (credit == '0);

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Two-VC weighted round-robin arbiter feeding one destination FIFO.
// Optional per-VC saturating grant counters are built when ARB_STATS_EN is defined.
module vc_wrr_arbiter
   import vc_wrr_arbiter_pkg::*;
#(
   parameter int BW = 4,
   parameter int W0 = 3,
   parameter int W1 = 1
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          VC0_empty,
   input  logic          VC1_empty,
   input  logic [BW-1:0] VC0_data_in,
   input  logic [BW-1:0] VC1_data_in,
   input  logic          D_almost_full,
   input  logic          arb_enable,
   output logic          VC0_rd,
   output logic          VC1_rd,
   output logic          D_wr,
   output logic [BW-1:0] D_data_out,
   output logic [1:0]    arb_state
`ifdef ARB_STATS_EN
   ,
   input  logic               stats_clr,
   output logic [STATS_W-1:0] VC0_grants,
   output logic [STATS_W-1:0] VC1_grants
`endif
);

   // state     | meaning
   // ST_IDLE   | no VC being served, no pops
   // ST_SERVE0 | VC0 owns the turn, pops while credit remains
   // ST_SERVE1 | VC1 owns the turn, pops while credit remains

   localparam logic [CREDIT_W-1:0] W0_C = CREDIT_W'(W0);
   localparam logic [CREDIT_W-1:0] W1_C = CREDIT_W'(W1);

   arb_state_t          state, state_nxt;
   logic                go, pop0, pop1, serve1;
   logic                cur_empty, oth_empty, exhausted;
   logic                cr_load, cr_zero;
   logic [CREDIT_W-1:0] credit, cr_val, cur_w, oth_w;
   logic                src_sel;

   assign go   = arb_enable & ~D_almost_full;
   assign pop0 = go & (state == ST_SERVE0) & ~VC0_empty;
   assign pop1 = go & (state == ST_SERVE1) & ~VC1_empty;

   assign serve1    = (state == ST_SERVE1);
   assign cur_empty = serve1 ? VC1_empty : VC0_empty;
   assign oth_empty = serve1 ? VC0_empty : VC1_empty;
   assign cur_w     = serve1 ? W1_C : W0_C;
   assign oth_w     = serve1 ? W0_C : W1_C;
   // credit of one means the pop being issued now is the last of this turn
   assign exhausted = cr_zero | (credit == CREDIT_W'(1));

   always_comb begin
      state_nxt = state;
      cr_load   = 1'b0;
      cr_val    = '0;
      case (state)
         ST_IDLE: begin
            if (go && !VC0_empty) begin
               state_nxt = ST_SERVE0;
               cr_load   = 1'b1;
               cr_val    = W0_C;
            end else if (go && !VC1_empty) begin
               state_nxt = ST_SERVE1;
               cr_load   = 1'b1;
               cr_val    = W1_C;
            end
         end
         ST_SERVE0, ST_SERVE1: begin
            if (go && (cur_empty || exhausted)) begin
               cr_load = 1'b1;
               if (!oth_empty) begin
                  state_nxt = serve1 ? ST_SERVE0 : ST_SERVE1;
                  cr_val    = oth_w;
               end else if (!cur_empty) begin
                  cr_val    = cur_w;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   wrr_credit_counter u_credit (
      .clk      (clk),
      .reset_L  (reset_L),
      .load     (cr_load),
      .load_val (cr_val),
      .dec      (pop0 | pop1),
      .credit   (credit),
      .zero     (cr_zero)
   );

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         D_wr    <= 1'b0;
         src_sel <= 1'b0;
      end else begin
         D_wr <= pop0 | pop1;
         if (pop1) begin
            src_sel <= 1'b1;
         end else if (pop0) begin
            src_sel <= 1'b0;
         end
      end
   end

   assign D_data_out = !D_wr ? '0 : (src_sel ? VC1_data_in : VC0_data_in);
   assign VC0_rd     = pop0;
   assign VC1_rd     = pop1;
   assign arb_state  = state;

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         VC0_grants <= '0;
         VC1_grants <= '0;
      end else if (stats_clr) begin
         VC0_grants <= '0;
         VC1_grants <= '0;
      end else begin
         if (pop0 && (VC0_grants != '1)) VC0_grants <= VC0_grants + 1'b1;
         if (pop1 && (VC1_grants != '1)) VC1_grants <= VC1_grants + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Randomized self-checking bench for vc_wrr_arbiter against a turn/weight model;
// the grant-statistics checks are compiled when ARB_STATS_EN is defined.
module tb_vc_wrr_arbiter;

   localparam int BW = 4;
   localparam int WT[2] = '{3, 1};

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          VC0_empty = 1'b1, VC1_empty = 1'b1;
   logic [BW-1:0] VC0_data_in = '0, VC1_data_in = '0;
   logic          D_almost_full = 1'b0, arb_enable = 1'b0;
   logic          VC0_rd, VC1_rd, D_wr;
   logic [BW-1:0] D_data_out;
   logic [1:0]    arb_state;
`ifdef ARB_STATS_EN
   logic          stats_clr = 1'b0;
   logic [7:0]    VC0_grants, VC1_grants;
`endif

   vc_wrr_arbiter #(.BW(BW), .W0(3), .W1(1)) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .VC0_empty     (VC0_empty),
      .VC1_empty     (VC1_empty),
      .VC0_data_in   (VC0_data_in),
      .VC1_data_in   (VC1_data_in),
      .D_almost_full (D_almost_full),
      .arb_enable    (arb_enable),
      .VC0_rd        (VC0_rd),
      .VC1_rd        (VC1_rd),
      .D_wr          (D_wr),
      .D_data_out    (D_data_out),
      .arb_state     (arb_state)
`ifdef ARB_STATS_EN
      ,
      .stats_clr     (stats_clr),
      .VC0_grants    (VC0_grants),
      .VC1_grants    (VC1_grants)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [BW-1:0] q0[$], q1[$];
   int            pop_log[$];
   logic          en_v = 1'b1, af_v = 1'b0;

   // reference: which VC owns the turn (0 none, 1 VC0, 2 VC1) and grants left in it
   int m_cur = 0;
   int m_rem = 0;
   int m_g0  = 0;
   int m_g1  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      logic n0, n1, go, e0, e1, p0, p1, nx, no;
      logic [BW-1:0] d;
      int x;
      @(negedge clk);
      arb_enable    = en_v;
      D_almost_full = af_v;
      n0 = (q0.size() != 0);
      n1 = (q1.size() != 0);
      VC0_empty = !n0;
      VC1_empty = !n1;
      #1;
      go = en_v && !af_v;
      e0 = go && (m_cur == 1) && n0;
      e1 = go && (m_cur == 2) && n1;
      chk("arb_state", 32'(arb_state), 32'(m_cur));
      chk("vc0_rd", 32'(VC0_rd), 32'(e0));
      chk("vc1_rd", 32'(VC1_rd), 32'(e1));
      p0 = (VC0_rd === 1'b1) && n0;
      p1 = (VC1_rd === 1'b1) && n1;
      d  = e0 ? q0[0] : (e1 ? q1[0] : '0);
      if (e0) m_g0++;
      if (e1) m_g1++;
      if (go) begin
         if (m_cur == 0) begin
            if (n0) begin m_cur = 1; m_rem = WT[0]; end
            else if (n1) begin m_cur = 2; m_rem = WT[1]; end
         end else begin
            x  = m_cur - 1;
            nx = (x == 1) ? n1 : n0;
            no = (x == 1) ? n0 : n1;
            if (nx) m_rem--;
            if (!nx || m_rem == 0) begin
               if (no) begin m_cur = 3 - m_cur; m_rem = WT[1 - x]; end
               else if (nx) m_rem = WT[x];
               else begin m_cur = 0; m_rem = 0; end
            end
         end
      end
      @(posedge clk);
      #1;
      if (p0) begin VC0_data_in = q0.pop_front(); pop_log.push_back(0); end
      if (p1) begin VC1_data_in = q1.pop_front(); pop_log.push_back(1); end
      #1;
      chk("d_wr", 32'(D_wr), 32'(e0 | e1));
      chk("d_data", 32'(D_data_out), (e0 | e1) ? 32'(d) : 32'd0);
   endtask

   task automatic fill(input int n0, input int n1);
      for (int i = 0; i < n0; i++) q0.push_back(BW'($urandom_range(1, 15)));
      for (int i = 0; i < n1; i++) q1.push_back(BW'($urandom_range(1, 15)));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, 32'(arb_state), 32'd0);
      chk({tag, "_rd0"},   32'(VC0_rd), 32'd0);
      chk({tag, "_rd1"},   32'(VC1_rd), 32'd0);
      chk({tag, "_dwr"},   32'(D_wr), 32'd0);
      chk({tag, "_data"},  32'(D_data_out), 32'd0);
   endtask

   // async reset at mid-cycle; release on a negedge with enable low so the model stays in step
   task automatic do_reset(input string tag);
      #3;
      reset_L = 1'b0;
      #1;
      check_reset_outputs(tag);
      m_cur = 0; m_rem = 0; m_g0 = 0; m_g1 = 0;
      q0.delete(); q1.delete();
      @(negedge clk);
      reset_L    = 1'b1;
      arb_enable = 1'b0;
   endtask

   initial begin
      int cnt;

      // reset held with traffic present: outputs must stay quiet
      VC0_empty  = 1'b0;
      arb_enable = 1'b1;
      #12;
      check_reset_outputs("por");
      @(negedge clk);
      reset_L    = 1'b1;
      arb_enable = 1'b0;
      VC0_empty  = 1'b1;

      // both VCs loaded: 3:1 grant pattern
      en_v = 1'b1; af_v = 1'b0;
      fill(8, 8);
      pop_log.delete();
      for (int i = 0; i < 24; i++) cycle();
      chk("wrr_log_len", 32'(pop_log.size() >= 8), 32'd1);
      if (pop_log.size() >= 8) begin
         for (int i = 0; i < 8; i++) chk("wrr_order", 32'(pop_log[i]), (i % 4 == 3) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 8; i++) cycle();

      // only VC1 with 5 entries, then back to idle
      fill(0, 5);
      pop_log.delete();
      for (int i = 0; i < 10; i++) cycle();
      chk("vc1_only_pops", 32'(pop_log.size()), 32'd5);
      chk("vc1_only_idle", 32'(arb_state), 32'd0);

      // almost-full after the second VC0 pop
      fill(8, 8);
      pop_log.delete();
      cnt = 0;
      while (pop_log.size() < 2 && cnt < 10) begin cycle(); cnt++; end
      chk("af_two_pops", 32'(pop_log.size()), 32'd2);
      af_v = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      chk("af_held", 32'(pop_log.size()), 32'd2);
      af_v = 1'b0;
      pop_log.delete();
      for (int i = 0; i < 4; i++) cycle();
      chk("af_resume_len", 32'(pop_log.size() >= 2), 32'd1);
      if (pop_log.size() >= 2) begin
         chk("af_resume_vc0", 32'(pop_log[0]), 32'd0);
         chk("af_resume_vc1", 32'(pop_log[1]), 32'd1);
      end

      // enable dropped right after a pop
      pop_log.delete();
      cnt = 0;
      while (pop_log.size() < 1 && cnt < 10) begin cycle(); cnt++; end
      chk("en_pop_seen", 32'(pop_log.size()), 32'd1);
      en_v = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("en_no_pops", 32'(pop_log.size()), 32'd1);
      en_v = 1'b1;
      for (int i = 0; i < 30; i++) cycle();

      // randomized traffic with backpressure and enable gaps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3 && q0.size() < 8) q0.push_back(BW'($urandom));
         if ($urandom_range(0, 9) < 3 && q1.size() < 8) q1.push_back(BW'($urandom));
         en_v = ($urandom_range(0, 9) != 0);
         af_v = ($urandom_range(0, 4) == 0);
         cycle();
      end
      en_v = 1'b1; af_v = 1'b0;

      // async reset in the middle of a VC0 burst
      do_reset("pre");
      fill(8, 0);
      pop_log.delete();
      cnt = 0;
      while (pop_log.size() < 1 && cnt < 10) begin cycle(); cnt++; end
      chk("mid_pop_seen", 32'(pop_log.size()), 32'd1);
      chk("mid_state", 32'(arb_state), 32'd1);
      do_reset("mid");
      fill(3, 2);
      for (int i = 0; i < 12; i++) cycle();

`ifdef ARB_STATS_EN
      do_reset("stats");
      fill(300, 0);
      cnt = 0;
      while (q0.size() != 0 && cnt < 400) begin cycle(); cnt++; end
      chk("stats_drained", 32'(q0.size()), 32'd0);
      chk("stats_g0", 32'(VC0_grants), (m_g0 > 255) ? 32'd255 : 32'(m_g0));
      chk("stats_g1", 32'(VC1_grants), 32'(m_g1));
      @(negedge clk);
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      chk("stats_clr_g0", 32'(VC0_grants), 32'd0);
      @(negedge clk);
      stats_clr = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vc_wrr_arbiter.md
VC_WRR_ARBITER -- requirements
Module: vc_wrr_arbiter

Interface
REQ-001 Parameter BW, default 4: data width of every VC FIFO and of the downstream FIFO.
REQ-002 Parameter W0, default 3: VC0 weight, i.e. consecutive grants per turn (legal 1..15).
REQ-003 Parameter W1, default 1: VC1 weight, i.e. consecutive grants per turn (legal 1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 VC0_empty, VC1_empty  input  1 each  empty flags of the VC0/VC1 source FIFOs.
REQ-007 VC0_data_in, VC1_data_in  input  BW each  source FIFO read data, valid the cycle after the matching rd.
REQ-008 D_almost_full  input  1  almost-full flag of the destination FIFO.
REQ-009 arb_enable  input  1  global grant enable.
REQ-010 VC0_rd, VC1_rd  output  1 each  source FIFO pop strobes.
REQ-011 D_wr  output  1  destination FIFO write strobe.
REQ-012 D_data_out  output  BW  destination FIFO write data.
REQ-013 arb_state  output  2  current FSM state: IDLE=0, SERVE0=1, SERVE1=2.

Function
REQ-014 The block SHALL assert at most one of VC0_rd/VC1_rd per cycle, never in the same cycle as each other.
REQ-015 A pop SHALL be issued only when arb_enable=1, D_almost_full=0, and the served VC's empty flag is 0; otherwise state and credit SHALL hold.
REQ-016 IDLE: VC0 non-empty -> SERVE0 with credit=W0; else VC1 non-empty -> SERVE1 with credit=W1; else stay; no pops in IDLE.
REQ-017 SERVEx: each issued pop SHALL decrement credit by 1 (4-bit unsigned, never wraps below 0).
REQ-018 SERVEx exit when credit reaches 0 or VCx becomes empty: other VC non-empty -> other SERVE state with its weight loaded; else VCx non-empty -> reload credit, stay; else IDLE.
REQ-019 Transition from SERVEx SHALL take effect the cycle after the last pop; the first pop of the new VC SHALL occur no earlier than that cycle.
REQ-020 D_wr SHALL equal the previous cycle's (VC0_rd | VC1_rd), a registered one-cycle delay.
REQ-021 D_data_out SHALL be VC0_data_in or VC1_data_in selected by a register capturing which VC was popped; it SHALL be 0 when D_wr=0.
REQ-022 A pop issued before arb_enable drops or D_almost_full rises SHALL still complete its D_wr the following cycle.
REQ-023 arb_state SHALL reflect the registered FSM state.

Reset
REQ-024 While reset_L=0: state=IDLE, credit=0, VC0_rd=VC1_rd=D_wr=0, D_data_out=0, source-select register=VC0; reset mid-burst SHALL discard any pending D_wr.

Configuration
REQ-025 With ARB_STATS_EN defined: outputs VC0_grants and VC1_grants (8 bits each) SHALL count pops per VC, saturate at 255, reset to 0; input stats_clr (1 bit) SHALL zero both synchronously, taking priority over a same-cycle increment.
REQ-026 Without ARB_STATS_EN: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package holds FSM state encodings (IDLE/SERVE0/SERVE1), credit width constant (4), and stats counter width (8).
REQ-028 One sub-module, wrr_credit_counter (load weight, decrement, zero flag), instantiated once and shared by both SERVE states.

Verification
REQ-029 Both VCs hold 8 entries, W0=3, W1=1, D_almost_full=0 -> pop order VC0,VC0,VC0,VC1 repeated; D_wr each cycle after a pop, data matches source.
REQ-030 Only VC1 non-empty with 5 entries -> IDLE->SERVE1, 5 pops with credit reload each time, then IDLE; VC0_rd never asserted.
REQ-031 D_almost_full raised mid-burst after 2nd VC0 pop -> no further pops, credit held at 1; on release exactly 1 more VC0 pop, then VC1.
REQ-032 arb_enable dropped in the cycle after a pop -> D_wr still asserted once with correct data; no new pops until re-enabled.
REQ-033 reset_L asserted asynchronously mid-SERVE0 -> all outputs 0 immediately, arb_state=0; after release restart from IDLE.
REQ-034 ARB_STATS_EN build, 300 VC0 pops -> VC0_grants=255 (saturated); stats_clr pulse -> 0 next cycle.
